kf8254_control_logic: RTL and testbench

//   Parametrised bus-interface/decode front end for an 8254-class timer with NUM_COUNTERS counters.

---
 rtl/kf8254_control_logic.sv | 182 ++++++++++++++++++
 tb/tb_kf8254_control_logic.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kf8254_control_logic.sv
// kf8254_control_logic: bus front end for an 8254-class timer.
// Captures CPU cycles and decodes them into per-counter strobes.
module kf8254_control_logic #(
    parameter int NUM_COUNTERS = 3,
    parameter int ADDR_WIDTH   = 2,
    parameter bit READBACK_EN  = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    chip_select_n,
    input  logic                    read_enable_n,
    input  logic                    write_enable_n,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [7:0]              data_bus_in,
    output logic [7:0]              internal_data_bus,
    output logic [NUM_COUNTERS-1:0] write_control,
    output logic [NUM_COUNTERS-1:0] latch_count,
    output logic [NUM_COUNTERS-1:0] latch_status,
    output logic [NUM_COUNTERS-1:0] write_counter,
    output logic [NUM_COUNTERS-1:0] read_counter,
    output logic [NUM_COUNTERS-1:0] read_done
);

    localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = '1;
    // Read-back can address at most counters 0..2
    localparam int RB_CNT = (NUM_COUNTERS < 3) ? NUM_COUNTERS : 3;

    logic                    wr_act;
    logic                    rd_act;
    logic                    wr_evt;
    logic                    rd_end;
    logic                    wr_prev_q;
    logic                    rd_prev_q;
    logic [7:0]              bus_q;
    logic [ADDR_WIDTH-1:0]   addr_hold_q;
    logic [1:0]              sc;

    logic [NUM_COUNTERS-1:0] wc_pend_d;
    logic [NUM_COUNTERS-1:0] wc_pend_q;
    logic [NUM_COUNTERS-1:0] lc_pend_d;
    logic [NUM_COUNTERS-1:0] lc_pend_q;
    logic [NUM_COUNTERS-1:0] ls_pend_d;
    logic [NUM_COUNTERS-1:0] ls_pend_q;
    logic [NUM_COUNTERS-1:0] wn_pend_d;
    logic [NUM_COUNTERS-1:0] wn_pend_q;

    logic [NUM_COUNTERS-1:0] wc_q;
    logic [NUM_COUNTERS-1:0] lc_q;
    logic [NUM_COUNTERS-1:0] ls_q;
    logic [NUM_COUNTERS-1:0] wn_q;
    logic [NUM_COUNTERS-1:0] rc_d;
    logic [NUM_COUNTERS-1:0] rc_q;
    logic [NUM_COUNTERS-1:0] rdone_d;
    logic [NUM_COUNTERS-1:0] rdone_q;

    logic                    unused_bus_bit;

    // Write beats read when both strobes are low
    assign wr_act = ~chip_select_n & ~write_enable_n;
    assign rd_act = ~chip_select_n & ~read_enable_n & write_enable_n;

    // Trailing edge of a write with chip select still asserted
    assign wr_evt = wr_prev_q & ~wr_act & ~chip_select_n;

    // A read that stops without being taken over by a write
    assign rd_end = rd_prev_q & ~rd_act & ~wr_act;

    assign sc = bus_q[7:6];

    assign unused_bus_bit = bus_q[0];

    // Decode the finished write from the held address and data
    always_comb begin
        wc_pend_d = '0;
        lc_pend_d = '0;
        ls_pend_d = '0;
        wn_pend_d = '0;
        if (wr_evt) begin
            if (addr_hold_q == CTRL_ADDR) begin
                if (sc == 2'b11) begin
                    if (READBACK_EN) begin
                        for (int k = 0; k < RB_CNT; k++) begin
                            if (bus_q[k+1]) begin
                                lc_pend_d[k] = ~bus_q[5];
                                ls_pend_d[k] = ~bus_q[4];
                            end
                        end
                    end
                end else begin
                    for (int i = 0; i < NUM_COUNTERS; i++) begin
                        if (int'(sc) == i) begin
                            if (bus_q[5:4] != 2'b00) begin
                                wc_pend_d[i] = 1'b1;
                            end else begin
                                lc_pend_d[i] = 1'b1;
                            end
                        end
                    end
                end
            end else begin
                for (int i = 0; i < NUM_COUNTERS; i++) begin
                    if (int'(addr_hold_q) == i) begin
                        wn_pend_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Live read select per counter and end-of-read target
    always_comb begin
        rc_d = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (rd_act && (int'(address) == i)) begin
                rc_d[i] = 1'b1;
            end
        end
        rdone_d = rd_end ? rc_q : '0;
    end

    // Bus capture and cycle history
    always_ff @(posedge clock) begin
        if (reset) begin
            bus_q       <= 8'h00;
            addr_hold_q <= '0;
            wr_prev_q   <= 1'b0;
            rd_prev_q   <= 1'b0;
        end else begin
            wr_prev_q <= wr_act;
            rd_prev_q <= rd_act;
            if (wr_act) begin
                bus_q       <= data_bus_in;
                addr_hold_q <= address;
            end else if (rd_act) begin
                addr_hold_q <= address;
            end
        end
    end

    // Two-stage strobe pipeline: decode stage then output stage
    always_ff @(posedge clock) begin
        if (reset) begin
            wc_pend_q <= '0;
            lc_pend_q <= '0;
            ls_pend_q <= '0;
            wn_pend_q <= '0;
            wc_q      <= '0;
            lc_q      <= '0;
            ls_q      <= '0;
            wn_q      <= '0;
        end else begin
            wc_pend_q <= wc_pend_d;
            lc_pend_q <= lc_pend_d;
            ls_pend_q <= ls_pend_d;
            wn_pend_q <= wn_pend_d;
            wc_q      <= wc_pend_q;
            lc_q      <= lc_pend_q;
            ls_q      <= ls_pend_q;
            wn_q      <= wn_pend_q;
        end
    end

    // Registered read level and read-done pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            rc_q    <= '0;
            rdone_q <= '0;
        end else begin
            rc_q    <= rc_d;
            rdone_q <= rdone_d;
        end
    end

    assign internal_data_bus = bus_q;
    assign write_control     = wc_q;
    assign latch_count       = lc_q;
    assign latch_status      = ls_q;
    assign write_counter     = wn_q;
    assign read_counter      = rc_q;
    assign read_done         = rdone_q;

endmodule

// File: tb/tb_kf8254_control_logic.sv
// tb_kf8254_control_logic: randomized bus cycles against a
// transaction-level expectation schedule, two parameter sets.
module tb_kf8254_control_logic;

    logic       clock = 1'b0;
    logic       reset;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic [1:0] addr;
    logic [7:0] din;

    logic [7:0] idb1;
    logic [2:0] wc1, lc1, ls1, wn1, rc1, rd1;
    logic [7:0] idb2;
    logic [1:0] wc2, lc2, ls2, wn2, rc2, rd2;

    typedef struct packed {
        logic [2:0] wc;
        logic [2:0] lc;
        logic [2:0] ls;
        logic [2:0] wn;
        logic [2:0] rc;
        logic [2:0] rd;
    } exp_t;

    exp_t       ex1[int];
    exp_t       ex2[int];
    int         edge_n = 0;
    int         n_chk  = 0;
    int         n_err  = 0;
    logic [7:0] m_idb  = 8'h00;

    always #5 clock = ~clock;

    kf8254_control_logic #(
        .NUM_COUNTERS(3),
        .ADDR_WIDTH(2),
        .READBACK_EN(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .chip_select_n(cs_n),
        .read_enable_n(rd_n),
        .write_enable_n(wr_n),
        .address(addr),
        .data_bus_in(din),
        .internal_data_bus(idb1),
        .write_control(wc1),
        .latch_count(lc1),
        .latch_status(ls1),
        .write_counter(wn1),
        .read_counter(rc1),
        .read_done(rd1)
    );

    kf8254_control_logic #(
        .NUM_COUNTERS(2),
        .ADDR_WIDTH(2),
        .READBACK_EN(1'b0)
    ) dut2 (
        .clock(clock),
        .reset(reset),
        .chip_select_n(cs_n),
        .read_enable_n(rd_n),
        .write_enable_n(wr_n),
        .address(addr),
        .data_bus_in(din),
        .internal_data_bus(idb2),
        .write_control(wc2),
        .latch_count(lc2),
        .latch_status(ls2),
        .write_counter(wn2),
        .read_counter(rc2),
        .read_done(rd2)
    );

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s edge=%0d got=%h exp=%h", tag, edge_n, got, exp);
        end
    endtask

    // Effect of a completed write, straight from the command rules
    function automatic exp_t wr_rule(input int a, input logic [7:0] d,
                                     input int n, input bit rb);
        exp_t r;
        int   sc;
        r  = '0;
        sc = int'(d[7:6]);
        if (a == 3) begin
            if (sc == 3) begin
                if (rb) begin
                    for (int k = 0; k < n && k < 3; k++) begin
                        if (d[k+1]) begin
                            r.lc[k] = ~d[5];
                            r.ls[k] = ~d[4];
                        end
                    end
                end
            end else if (sc < n) begin
                if (d[5:4] != 2'b00) r.wc[sc] = 1'b1;
                else r.lc[sc] = 1'b1;
            end
        end else if (a < n) begin
            r.wn[a] = 1'b1;
        end
        return r;
    endfunction

    function automatic exp_t sel(input int a, input int n);
        exp_t r;
        r = '0;
        if (a < n) r.rc[a] = 1'b1;
        return r;
    endfunction

    task automatic sched(input int e, input exp_t x1, input exp_t x2);
        if (!ex1.exists(e)) ex1[e] = '0;
        if (!ex2.exists(e)) ex2[e] = '0;
        ex1[e] = ex1[e] | x1;
        ex2[e] = ex2[e] | x2;
    endtask

    task automatic step();
        exp_t e1;
        exp_t e2;
        @(posedge clock);
        edge_n++;
        #1;
        e1 = '0;
        e2 = '0;
        if (ex1.exists(edge_n)) e1 = ex1[edge_n];
        if (ex2.exists(edge_n)) e2 = ex2[edge_n];
        chk("d1_idb", idb1, m_idb);
        chk("d1_wc", {5'b0, wc1}, {5'b0, e1.wc});
        chk("d1_lc", {5'b0, lc1}, {5'b0, e1.lc});
        chk("d1_ls", {5'b0, ls1}, {5'b0, e1.ls});
        chk("d1_wn", {5'b0, wn1}, {5'b0, e1.wn});
        chk("d1_rc", {5'b0, rc1}, {5'b0, e1.rc});
        chk("d1_rd", {5'b0, rd1}, {5'b0, e1.rd});
        chk("d2_idb", idb2, m_idb);
        chk("d2_wc", {6'b0, wc2}, {5'b0, e2.wc});
        chk("d2_lc", {6'b0, lc2}, {5'b0, e2.lc});
        chk("d2_ls", {6'b0, ls2}, {5'b0, e2.ls});
        chk("d2_wn", {6'b0, wn2}, {5'b0, e2.wn});
        chk("d2_rc", {6'b0, rc2}, {5'b0, e2.rc});
        chk("d2_rd", {6'b0, rd2}, {5'b0, e2.rd});
    endtask

    task automatic drv(input bit r, input bit c, input bit rd,
                       input bit wr, input logic [1:0] a,
                       input logic [7:0] d);
        reset = r;
        cs_n  = c;
        rd_n  = rd;
        wr_n  = wr;
        addr  = a;
        din   = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drv(0, 1, 1, 1, 2'($urandom), 8'($urandom));
            step();
        end
    endtask

    task automatic op_write(input int a, input logic [7:0] d,
                            input int len, input bit both, input bit mv);
        logic [1:0] aa;
        logic [7:0] dd;
        for (int i = 0; i < len; i++) begin
            if (i == len - 1) begin
                aa = 2'(a);
                dd = d;
            end else begin
                aa = mv ? 2'($urandom) : 2'(a);
                dd = 8'($urandom);
            end
            drv(0, 0, !both, 0, aa, dd);
            m_idb = dd;
            step();
        end
        drv(0, 0, 1, 1, 2'(a), 8'($urandom));
        sched(edge_n + 2, wr_rule(a, d, 3, 1'b1), wr_rule(a, d, 2, 1'b0));
        step();
        idle(1 + $urandom_range(0, 2));
    endtask

    task automatic op_read(input int a, input int b, input int len,
                           input bit cs_end, input bit mv);
        int aa;
        for (int i = 0; i < len; i++) begin
            aa = (mv && i < len / 2) ? b : a;
            drv(0, 0, 0, 1, 2'(aa), 8'($urandom));
            sched(edge_n + 1, sel(aa, 3), sel(aa, 2));
            step();
        end
        if (cs_end) drv(0, 1, 0, 1, 2'(a), 8'($urandom));
        else drv(0, 0, 1, 1, 2'(a), 8'($urandom));
        begin
            exp_t r1;
            exp_t r2;
            r1 = '0;
            r2 = '0;
            r1.rd = sel(a, 3).rc;
            r2.rd = sel(a, 2).rc;
            sched(edge_n + 1, r1, r2);
        end
        step();
        idle(1 + $urandom_range(0, 2));
    endtask

    task automatic op_abort(input int a, input logic [7:0] d, input int len);
        for (int i = 0; i < len; i++) begin
            drv(0, 0, 1, 0, 2'(a), d);
            m_idb = d;
            step();
        end
        drv(0, 1, 1, 0, 2'(a), d);
        step();
        idle(1 + $urandom_range(0, 2));
    endtask

    task automatic op_reset(input int a, input logic [7:0] d,
                            input int len, input int rlen);
        for (int i = 0; i < len; i++) begin
            drv(0, 0, 1, 0, 2'(a), d);
            m_idb = d;
            step();
        end
        for (int i = 0; i < rlen; i++) begin
            drv(1, 0, 1, 0, 2'(a), d);
            m_idb = 8'h00;
            step();
        end
        drv(0, 0, 1, 1, 2'(a), d);
        step();
        idle(1 + $urandom_range(0, 2));
    endtask

    initial begin
        drv(1, 1, 1, 1, 2'd0, 8'h00);
        step();
        step();
        idle(2);

        op_write(3, 8'h34, 2, 0, 0);
        op_write(1, 8'hAB, 2, 0, 0);
        op_write(3, 8'h40, 1, 0, 0);
        op_write(3, 8'hCE, 2, 0, 0);
        op_write(3, 8'hE4, 1, 0, 0);
        op_read(2, 2, 3, 0, 0);
        op_read(3, 3, 2, 0, 0);
        op_read(1, 0, 4, 1, 1);
        op_abort(3, 8'h34, 2);
        op_write(0, 8'h5A, 2, 1, 0);
        op_reset(3, 8'h34, 2, 1);
        op_write(3, 8'h94, 2, 0, 0);
        op_write(2, 8'h77, 3, 0, 1);

        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                op_write($urandom_range(0, 3), 8'($urandom),
                         $urandom_range(1, 3), 0, $urandom_range(0, 3) == 0);
            end else if (r <= 6) begin
                if ($urandom_range(0, 2) == 0)
                    op_read($urandom_range(0, 1), $urandom_range(0, 1),
                            $urandom_range(2, 4), 1'($urandom), 1);
                else
                    op_read($urandom_range(0, 3), 0,
                            $urandom_range(1, 4), 1'($urandom), 0);
            end else if (r == 7) begin
                op_abort($urandom_range(0, 3), 8'($urandom),
                         $urandom_range(1, 3));
            end else if (r == 8) begin
                op_write($urandom_range(0, 3), 8'($urandom),
                         $urandom_range(1, 3), 1, 0);
            end else begin
                op_reset($urandom_range(0, 3), 8'($urandom),
                         $urandom_range(1, 3), $urandom_range(1, 2));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
